// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv unit.
// The divider FSM states, default datapath width and the most-negative operand value live here.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF);
    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// It shifts {rem,q} left by one bit, then keeps the difference when the trial subtraction does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so the WIDTH+1-bit difference never overflows and its MSB is the sign.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Sequential signed divider: WIDTH restoring steps on magnitudes, followed by one sign-fix cycle.
// Results come with a one-cycle resultReady pulse and are held until the next result.
module div_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             dataReset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             resultReady,
    output logic             busy
);

    localparam int C_W = $clog2(WIDTH);
    localparam logic [C_W-1:0] LAST = C_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [C_W-1:0]   count;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic             qsign;
    logic             rsign;
    logic             divzero;
    logic             ovf;

    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;

    // The magnitude of MIN_VAL wraps to MIN_VAL itself, which is the correct value when read as unsigned.
    assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[WIDTH-1] ? -divisor : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_r),
        .q       (q_r),
        .divisor (dvs_r),
        .rem_nxt (rem_nxt),
        .q_nxt   (q_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge dataReset_n) begin
        if (!dataReset_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            dvs_r       <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            divzero     <= 1'b0;
            ovf         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            exception   <= 1'b0;
            resultReady <= 1'b0;
            busy        <= 1'b0;
        end else begin
            resultReady <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        q_r     <= dividend_abs;
                        rem_r   <= '0;
                        dvs_r   <= divisor_abs;
                        rsign   <= dividend[WIDTH-1];
                        qsign   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        divzero <= (divisor == '0);
                        ovf     <= (dividend == MIN_VAL) && (divisor == '1);
                        count   <= '0;
                        state   <= (divisor == '0) ? FIX : DIV;
                    end
                end
                DIV: begin
                    rem_r <= rem_nxt;
                    q_r   <= q_nxt;
                    count <= count + C_W'(1);
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    resultReady <= 1'b1;
                    count       <= '0;
                    state       <= IDLE;
                    if (divzero) begin
                        // q_r still holds |dividend| untouched, so the original operand can be rebuilt from it.
                        quotient  <= '0;
                        remainder <= rsign ? -q_r : q_r;
                        exception <= 1'b1;
                    end else begin
                        quotient  <= qsign ? -q_r : q_r;
                        remainder <= rsign ? -rem_r : rem_r;
                        exception <= ovf;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter.
// It checks latency, signed results, exception cases, start handling while busy, and reset in the middle of a division.
module tb_div_iter;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         dataReset_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         exception;
    logic         resultReady;
    logic         busy;

    int tests  = 0;
    int failed = 0;

    div_iter #(.WIDTH(W)) dut (
        .clock       (clock),
        .dataReset_n (dataReset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .exception   (exception),
        .resultReady (resultReady),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one division; lat is the expected number of edges after the accepting edge before resultReady is seen.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ex,
                           input int lat);
        int n;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check({tag, " busy_after_start"}, W'(busy), 32'd1);
        n = 0;
        while (!resultReady && n < 100) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        check({tag, " latency"}, W'(n), W'(lat));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " exception"}, W'(exception), W'(ex));
        check({tag, " busy_on_ready"}, W'(busy), 32'd1);
        @(negedge clock);
        check({tag, " ready_pulse_width"}, W'(resultReady), 32'd0);
        check({tag, " busy_after_ready"}, W'(busy), 32'd0);
        check({tag, " quotient_held"}, quotient, eq);
        check({tag, " remainder_held"}, remainder, er);
    endtask

    initial begin
        int nr;
        int r1;
        int r2;

        dataReset_n = 1'b0;
        start       = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #12;
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset exception", W'(exception), 32'd0);
        check("reset ready", W'(resultReady), 32'd0);
        check("reset busy", W'(busy), 32'd0);
        @(negedge clock);
        dataReset_n = 1'b1;

        run_div("100/7",   32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33);
        run_div("-100/7",  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
        run_div("100/-7",  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 33);
        run_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 33);
        run_div("7/0",     32'd7,         32'd0,         32'd0,         32'd7,         1'b1, 1);
        run_div("-5/0",    32'hFFFF_FFFB, 32'd0,         32'd0,         32'hFFFF_FFFB, 1'b1, 1);
        run_div("min/-1",  INT_MIN,       32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b1, 33);
        run_div("min/1",   INT_MIN,       32'd1,         32'h8000_0000, 32'd0,         1'b0, 33);
        run_div("1/max",   32'd1,         32'h7FFF_FFFF, 32'd0,         32'd1,         1'b0, 33);

        // Start held high for 40 cycles: only the first start and the start on the cycle after the result are accepted.
        @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        nr = 0;
        r1 = -1;
        r2 = -1;
        for (int e = 0; e < 80; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (e == 39) start = 1'b0;
            if (resultReady) begin
                nr++;
                check("held quotient", quotient, 32'd10);
                check("held remainder", remainder, 32'd0);
                if (nr == 1) r1 = e;
                else if (nr == 2) r2 = e;
            end
        end
        check("held result count", W'(nr), 32'd2);
        check("held first edge", W'(r1), 32'd33);
        check("held second edge", W'(r2), 32'd67);

        // Give the outputs a nonzero value first, so clearing them on reset can be seen.
        run_div("pre_reset 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        dataReset_n = 1'b0;
        #1;
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        check("midreset exception", W'(exception), 32'd0);
        check("midreset ready", W'(resultReady), 32'd0);
        check("midreset busy", W'(busy), 32'd0);
        @(negedge clock);
        dataReset_n = 1'b1;
        @(negedge clock);
        check("post_reset idle busy", W'(busy), 32'd0);
        run_div("9/3 after reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
